// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register drives a combinational-read instruction memory,
// captures the returned word into a one-entry output register with a valid/ready handshake.
module instruction_fetch #(
    parameter int                        MEM_ADDR_WIDTH = 32,
    parameter int                        MEM_DATA_WIDTH = 32,
    parameter logic [MEM_ADDR_WIDTH-1:0] RESET_PC       = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      halt,
    input  logic                      redirect_valid,
    input  logic [MEM_ADDR_WIDTH-1:0] redirect_addr,
    output logic [MEM_ADDR_WIDTH-1:0] address,
    input  logic [MEM_DATA_WIDTH-1:0] instruction,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [MEM_DATA_WIDTH-1:0] out_instruction,
    output logic [MEM_ADDR_WIDTH-1:0] out_pc
);

    // state | meaning
    // IDLE  | no fetching; a held word may still drain through the handshake
    // RUN   | fetch one word per cycle whenever the output register is free
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                    state_q;
    logic [MEM_ADDR_WIDTH-1:0] pc_q;
    logic [MEM_ADDR_WIDTH-1:0] pc_d;
    logic                      out_valid_q;
    logic [MEM_DATA_WIDTH-1:0] out_instruction_q;
    logic [MEM_ADDR_WIDTH-1:0] out_pc_q;
    logic                      fetch_en;

    // Redirect and halt both suppress the fetch of the current cycle.
    assign fetch_en = (state_q == RUN) && !halt && !redirect_valid
                      && (!out_valid_q || out_ready);
    assign pc_d     = pc_q + MEM_ADDR_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            pc_q              <= RESET_PC;
            out_valid_q       <= 1'b0;
            out_instruction_q <= '0;
            out_pc_q          <= '0;
        end else begin
            case (state_q)
                IDLE:    if (start && !halt) state_q <= RUN;
                RUN:     if (halt)           state_q <= IDLE;
                default:                     state_q <= IDLE;
            endcase

            if (redirect_valid) begin
                pc_q        <= redirect_addr;
                out_valid_q <= 1'b0;
            end else if (fetch_en) begin
                pc_q              <= pc_d;
                out_valid_q       <= 1'b1;
                out_instruction_q <= instruction;
                out_pc_q          <= pc_q;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign address         = pc_q;
    assign out_valid       = out_valid_q;
    assign out_instruction = out_instruction_q;
    assign out_pc          = out_pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        halt;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic [31:0] address;
    logic [31:0] instruction;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;

    int n_checks = 0;
    int n_fails  = 0;

    instruction_fetch #(
        .MEM_ADDR_WIDTH(32),
        .MEM_DATA_WIDTH(32),
        .RESET_PC      (32'h0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .address        (address),
        .instruction    (instruction),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instruction(out_instruction),
        .out_pc         (out_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'd0:   return 32'h0000_1101;
            32'd1:   return 32'h0000_3123;
            32'd2:   return 32'h0000_312B;
            default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
        endcase
    endfunction

    assign instruction = mem_word(address);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst_n = 1'b1; start = 1'b0; halt = 1'b0;
        redirect_valid = 1'b0; redirect_addr = 32'h0; out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Observed tuple {out_valid, out_pc, out_instruction, address}
    function automatic logic [96:0] obs();
        return {out_valid, out_pc, out_instruction, address};
    endfunction

    task automatic test_reset();
        logic [96:0] exp;
        idle_inputs();
        rst_n = 1'b0; start = 1'b1; out_ready = 1'b1; redirect_valid = 1'b1;
        redirect_addr = 32'h1234;
        tick();
        exp = {1'b0, 32'h0, 32'h0, 32'h0};
        n_checks++;
        if (obs() !== exp) begin
            n_fails++;
            $display("FAIL reset: got %h expected %h", obs(), exp);
        end
        idle_inputs();
    endtask

    task automatic test_basic_stream();
        logic [96:0] exp;
        logic [31:0] words [3];
        words[0] = 32'h1101; words[1] = 32'h3123; words[2] = 32'h312B;
        do_reset();
        start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        exp = {1'b0, 32'h0, 32'h0, 32'h0};
        n_checks++;
        if (obs() !== exp) begin
            n_fails++;
            $display("FAIL start_no_fetch: got %h expected %h", obs(), exp);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            exp = {1'b1, 32'(i), words[i], 32'(i + 1)};
            n_checks++;
            if (obs() !== exp) begin
                n_fails++;
                $display("FAIL stream_word%0d: got %h expected %h", i, obs(), exp);
            end
        end
    endtask

    task automatic test_stall();
        logic [96:0] exp;
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0; out_ready = 1'b0;
        tick();
        exp = {1'b1, 32'h0, 32'h1101, 32'h1};
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (obs() !== exp) begin
                n_fails++;
                $display("FAIL stall_hold%0d: got %h expected %h", i, obs(), exp);
            end
        end
        out_ready = 1'b1;
        tick();
        exp = {1'b1, 32'h1, 32'h3123, 32'h2};
        n_checks++;
        if (obs() !== exp) begin
            n_fails++;
            $display("FAIL stall_resume: got %h expected %h", obs(), exp);
        end
        out_ready = 1'b0;
        tick();
    endtask

    // Continues from test_stall: word pending, out_ready low.
    task automatic test_redirect();
        logic [96:0] exp;
        redirect_valid = 1'b1; redirect_addr = 32'h0A;
        tick();
        redirect_valid = 1'b0;
        n_checks++;
        if ({out_valid, address} !== {1'b0, 32'h0A}) begin
            n_fails++;
            $display("FAIL redirect_flush: got valid=%b addr=%h expected valid=0 addr=0000000a",
                     out_valid, address);
        end
        tick();
        exp = {1'b1, 32'h0A, mem_word(32'h0A), 32'h0B};
        n_checks++;
        if (obs() !== exp) begin
            n_fails++;
            $display("FAIL redirect_target: got %h expected %h", obs(), exp);
        end
    endtask

    task automatic test_wrap();
        logic [96:0] exp;
        redirect_valid = 1'b1; redirect_addr = 32'hFFFF_FFFF; out_ready = 1'b1;
        tick();
        redirect_valid = 1'b0; out_ready = 1'b0;
        tick();
        exp = {1'b1, 32'hFFFF_FFFF, mem_word(32'hFFFF_FFFF), 32'h0};
        n_checks++;
        if (obs() !== exp) begin
            n_fails++;
            $display("FAIL pc_wrap: got %h expected %h", obs(), exp);
        end
    endtask

    // Continues from test_wrap: word at 0xFFFFFFFF pending.
    task automatic test_halt();
        logic [96:0] exp;
        exp = {1'b1, 32'hFFFF_FFFF, mem_word(32'hFFFF_FFFF), 32'h0};
        halt = 1'b1;
        tick();
        halt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs() !== exp) begin
                n_fails++;
                $display("FAIL halt_hold%0d: got %h expected %h", i, obs(), exp);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({out_valid, address} !== {1'b0, 32'h0}) begin
                n_fails++;
                $display("FAIL halt_drained%0d: got valid=%b addr=%h expected valid=0 addr=00000000",
                         i, out_valid, address);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_start_with_halt();
        do_reset();
        start = 1'b1; halt = 1'b1;
        tick();
        start = 1'b0; halt = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({out_valid, address} !== {1'b0, 32'h0}) begin
            n_fails++;
            $display("FAIL start_halt_idle: got valid=%b addr=%h expected valid=0 addr=00000000",
                     out_valid, address);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_run();
        logic [96:0] exp;
        do_reset();
        start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp = {1'b0, 32'h0, 32'h0, 32'h0};
        n_checks++;
        if (obs() !== exp) begin
            n_fails++;
            $display("FAIL reset_mid_run: got %h expected %h", obs(), exp);
        end
        tick();
        tick();
        n_checks++;
        if (obs() !== exp) begin
            n_fails++;
            $display("FAIL reset_needs_start: got %h expected %h", obs(), exp);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        exp = {1'b1, 32'h0, 32'h1101, 32'h1};
        n_checks++;
        if (obs() !== exp) begin
            n_fails++;
            $display("FAIL restart_after_reset: got %h expected %h", obs(), exp);
        end
        idle_inputs();
    endtask

    // Reference model: fetching/idle flag, PC and the single output word.
    bit          m_run;
    logic [31:0] m_pc;
    bit          m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_opc;

    task automatic model_step();
        bit take;
        if (!rst_n) begin
            m_run = 0; m_pc = 32'h0; m_valid = 0; m_instr = 32'h0; m_opc = 32'h0;
            return;
        end
        take = m_run && !halt && !redirect_valid && (!m_valid || out_ready);
        if (redirect_valid) begin
            m_pc = redirect_addr;
            m_valid = 0;
        end else if (take) begin
            m_instr = mem_word(m_pc);
            m_opc   = m_pc;
            m_valid = 1;
            m_pc    = m_pc + 32'd1;
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        if (halt)       m_run = 0;
        else if (start) m_run = 1;
    endtask

    task automatic test_random();
        logic [96:0] exp;
        do_reset();
        m_run = 0; m_pc = 32'h0; m_valid = 0; m_instr = 32'h0; m_opc = 32'h0;
        for (int i = 0; i < 400; i++) begin
            rst_n          = ($urandom_range(0, 59) != 0);
            start          = ($urandom_range(0, 3) == 0);
            halt           = ($urandom_range(0, 11) == 0);
            redirect_valid = ($urandom_range(0, 13) == 0);
            redirect_addr  = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFE + 32'($urandom_range(0, 1))
                                                          : 32'($urandom);
            out_ready      = ($urandom_range(0, 2) != 0);
            model_step();
            tick();
            exp = {m_valid, m_opc, m_instr, m_pc};
            n_checks++;
            if (obs() !== exp) begin
                n_fails++;
                $display("FAIL random_cycle%0d: got %h expected %h", i, obs(), exp);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_basic_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_halt();
        test_start_with_halt();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter MEM_ADDR_WIDTH, default 32, meaning the width of the word address / PC.
REQ-002 SHALL have parameter MEM_DATA_WIDTH, default 32, meaning the instruction word width.
REQ-003 SHALL have parameter RESET_PC, default 0, meaning the PC value loaded at reset.
REQ-004 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port start  input  1  request to leave IDLE and begin fetching.
REQ-007 SHALL have port halt  input  1  request to stop fetching and return to IDLE.
REQ-008 SHALL have port redirect_valid  input  1  branch/jump redirect strobe.
REQ-009 SHALL have port redirect_addr  input  MEM_ADDR_WIDTH  redirect target word address.
REQ-010 SHALL have port address  output  MEM_ADDR_WIDTH  word address to instruction memory (combinational read).
REQ-011 SHALL have port instruction  input  MEM_DATA_WIDTH  word returned by instruction memory, same cycle.
REQ-012 SHALL have port out_valid  output  1  out_instruction/out_pc hold a fetched word.
REQ-013 SHALL have port out_ready  input  1  decode stage accepts the word this cycle.
REQ-014 SHALL have port out_instruction  output  MEM_DATA_WIDTH  registered fetched word.
REQ-015 SHALL have port out_pc  output  MEM_ADDR_WIDTH  word address of out_instruction.

Function
REQ-016 SHALL hold a PC register; address SHALL equal PC combinationally at all times.
REQ-017 SHALL implement two states, IDLE and RUN.
REQ-018 SHALL fetch in RUN when out_valid=0 or out_ready=1: capture out_instruction=instruction and out_pc=PC, set out_valid=1, and set PC=PC+1.
REQ-019 SHALL increment PC by 1 word modulo 2^MEM_ADDR_WIDTH, so all-ones wraps to 0.
REQ-020 SHALL give a latency of one cycle from PC presented on address to the word on out_instruction.
REQ-021 SHALL sustain a throughput of one word per cycle while out_ready=1.
REQ-022 SHALL stall while out_valid=1 and out_ready=0: PC, out_instruction, out_pc and out_valid unchanged.
REQ-023 SHALL clear out_valid in a cycle with out_valid=1 and out_ready=1 when no new fetch occurs.
REQ-024 SHALL move IDLE->RUN on start=1 with halt=0; PC SHALL be unchanged and there SHALL be no fetch in the transition cycle.
REQ-025 SHALL move RUN->IDLE on halt=1; there SHALL be no fetch in that cycle, PC SHALL be unchanged, and a pending out_valid word SHALL remain until accepted.
REQ-026 SHALL treat start=1 and halt=1 together in IDLE as halt, staying in IDLE.
REQ-027 SHALL, on redirect_valid=1 in any state, set PC=redirect_addr, force out_valid=0 (flush, regardless of out_ready), and perform no fetch that cycle.
REQ-028 SHALL give redirect priority over fetch and stall; redirect+halt in RUN SHALL load PC, flush, and go to IDLE.
REQ-029 SHALL, in IDLE, never fetch; out_valid SHALL only fall on handshake or redirect.

Reset
REQ-030 SHALL, when rst_n=0 at a clock edge, set PC=RESET_PC, state=IDLE, out_valid=0, out_instruction=0 and out_pc=0, overriding all other inputs.
REQ-031 SHALL, on reset asserted mid-RUN, discard any pending word, with outputs equal to reset values the following cycle.

Verification
REQ-032 SHALL verify: reset, start pulse, out_ready=1, memory[0..2]=0x1101,0x3123,0x312B -> out_valid from cycle 2, out_pc 0,1,2 on consecutive cycles with matching words.
REQ-033 SHALL verify: RUN with out_ready=0 for 3 cycles after the first capture -> out_pc=0 and out_instruction=0x1101 held, address stays 1, then resumes with out_pc=1.
REQ-034 SHALL verify: redirect_valid=1 with redirect_addr=0x0A while out_valid=1 and out_ready=0 -> next cycle out_valid=0 and address=0x0A, following word has out_pc=0x0A.
REQ-035 SHALL verify: PC=0xFFFFFFFF fetched -> out_pc=0xFFFFFFFF and next address=0.
REQ-036 SHALL verify: halt in RUN with pending word -> state IDLE, word held until out_ready=1, then out_valid=0 and no further fetches.
REQ-037 SHALL verify: rst_n=0 mid-stream with out_valid=1 -> next cycle out_valid=0, outputs 0, address=RESET_PC, and start required to resume.
